// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types, response codes and sizing helpers for the
// terminating (error) slave and its queues.
package axi4_lite_pkg;

    typedef struct packed {
        int unsigned a;  // address width
        int unsigned n;  // data bytes
        int unsigned i;  // ID width, 0 = no ID
    } axi4_lite_cfg_t;

    localparam axi4_lite_cfg_t CFG_DEFAULT = '{a: 32, n: 4, i: 4};

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Pointer width for a queue of the given depth; never narrower than one bit.
    function automatic int unsigned depth_bits(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite channel bundle; ID fields keep one bit when the ID width is zero.
interface axi4_lite_if
    import axi4_lite_pkg::*;
#(
    parameter axi4_lite_cfg_t CFG = CFG_DEFAULT
);
    localparam int unsigned IW = (CFG.i == 0) ? 1 : CFG.i;

    logic                 awvalid;
    logic                 awready;
    logic [CFG.a-1:0]     awaddr;
    logic [IW-1:0]        awid;
    logic                 wvalid;
    logic                 wready;
    logic [CFG.n*8-1:0]   wdata;
    logic [CFG.n-1:0]     wstrb;
    logic                 bvalid;
    logic                 bready;
    logic [IW-1:0]        bid;
    logic [1:0]           bresp;
    logic                 arvalid;
    logic                 arready;
    logic [CFG.a-1:0]     araddr;
    logic [IW-1:0]        arid;
    logic                 rvalid;
    logic                 rready;
    logic [IW-1:0]        rid;
    logic [CFG.n*8-1:0]   rdata;
    logic [1:0]           rresp;

    modport slave (
        input  awvalid, awaddr, awid, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, arid, rready,
        output awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rdata, rresp
    );

    modport master (
        output awvalid, awaddr, awid, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, arid, rready,
        input  awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rdata, rresp
    );

endinterface

// File: rtl/axi4_lite_id_fifo.sv
// Small ID FIFO with registered pointers; with W = 0 it keeps only an occupancy count.
module axi4_lite_id_fifo
    import axi4_lite_pkg::*;
#(
    parameter int unsigned W     = 0,
    parameter int unsigned DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic [((W == 0) ? 1 : W)-1:0] din,
    output logic [((W == 0) ? 1 : W)-1:0] dout,
    output logic                          full,
    output logic                          empty
);
    localparam int unsigned WS   = (W == 0) ? 1 : W;
    localparam int unsigned CNTW = $clog2(DEPTH + 1);
    localparam int unsigned PW   = depth_bits(DEPTH);

    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            push_en, pop_en;

    assign full    = (cnt_q == CNTW'(DEPTH));
    assign empty   = (cnt_q == '0);
    // No pass-through: a full queue refuses a push even when popping.
    assign push_en = push & ~full;
    assign pop_en  = pop & ~empty;

    always_comb begin
        cnt_d = cnt_q;
        case ({push_en, pop_en})
            2'b10:   cnt_d = cnt_q + CNTW'(1);
            2'b01:   cnt_d = cnt_q - CNTW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    if (W > 0) begin : g_store
        logic [WS-1:0] mem_q [DEPTH];
        logic [PW-1:0] wr_ptr_q, rd_ptr_q;

        function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
            return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
        endfunction

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push_en) wr_ptr_q <= next_ptr(wr_ptr_q);
                if (pop_en)  rd_ptr_q <= next_ptr(rd_ptr_q);
            end
        end

        always_ff @(posedge clk) begin
            if (push_en) mem_q[wr_ptr_q] <= din;
        end

        assign dout = mem_q[rd_ptr_q];
    end else begin : g_count_only
        logic unused_din;
        assign unused_din = ^din;
        assign dout       = '0;
    end

endmodule

// File: rtl/axi4_lite_error_slave.sv
// Terminating AXI4-Lite slave for unmapped space: answers every access with a fixed
// response and read pattern, in order, and keeps debug hit counters and addresses.
module axi4_lite_error_slave
    import axi4_lite_pkg::*;
#(
    parameter axi4_lite_cfg_t CONFIG = CFG_DEFAULT,
    parameter logic [31:0]    D      = 32'hbaadc0de,
    parameter logic [1:0]     RESP   = RESP_DECERR,
    parameter int unsigned    DEPTH  = 2,
    parameter int unsigned    CW     = 16
) (
    input  logic                aclk,
    input  logic                aresetn,
    axi4_lite_if.slave          axi4_s,
    input  logic                clr,
    output logic [CW-1:0]       wr_hits,
    output logic [CW-1:0]       rd_hits,
    output logic [CONFIG.a-1:0] last_waddr,
    output logic [CONFIG.a-1:0] last_raddr,
    output logic                hit
);
    localparam int unsigned IW  = (CONFIG.i == 0) ? 1 : CONFIG.i;
    localparam int unsigned DW  = CONFIG.n * 8;
    localparam int unsigned WCW = $clog2(DEPTH + 1);

    function automatic logic [DW-1:0] fill_pattern();
        logic [DW-1:0] p;
        for (int b = 0; b < int'(DW); b++) p[b] = D[b % 32];
        return p;
    endfunction

    localparam logic [DW-1:0] RDATA = fill_pattern();

    logic                aw_full, aw_empty, ar_full, ar_empty;
    logic [IW-1:0]       aw_head, ar_head;
    logic                aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic                w_ready, b_go, r_go;
    logic [WCW-1:0]      wcnt_q, wcnt_d;
    logic                bvalid_q, rvalid_q;
    logic [IW-1:0]       bid_q, rid_q;
    logic [CW-1:0]       wr_hits_q, rd_hits_q;
    logic [CONFIG.a-1:0] last_waddr_q, last_raddr_q;
    logic                hit_q;
    logic                unused_w;

    assign unused_w = ^{axi4_s.wdata, axi4_s.wstrb};

    assign w_ready = (wcnt_q != WCW'(DEPTH));
    assign aw_hs   = axi4_s.awvalid & ~aw_full;
    assign w_hs    = axi4_s.wvalid & w_ready;
    assign ar_hs   = axi4_s.arvalid & ~ar_full;
    assign b_hs    = bvalid_q & axi4_s.bready;
    assign r_hs    = rvalid_q & axi4_s.rready;

    // Responses only issue from registered queue state, so the payload loads on an
    // edge where the channel is idle or completing.
    assign b_go = ~aw_empty & (wcnt_q != '0) & (~bvalid_q | axi4_s.bready);
    assign r_go = ~ar_empty & (~rvalid_q | axi4_s.rready);

    axi4_lite_id_fifo #(
        .W     (CONFIG.i),
        .DEPTH (DEPTH)
    ) u_aw_fifo (
        .clk   (aclk),
        .rst_n (aresetn),
        .push  (aw_hs),
        .pop   (b_go),
        .din   (axi4_s.awid),
        .dout  (aw_head),
        .full  (aw_full),
        .empty (aw_empty)
    );

    axi4_lite_id_fifo #(
        .W     (CONFIG.i),
        .DEPTH (DEPTH)
    ) u_ar_fifo (
        .clk   (aclk),
        .rst_n (aresetn),
        .push  (ar_hs),
        .pop   (r_go),
        .din   (axi4_s.arid),
        .dout  (ar_head),
        .full  (ar_full),
        .empty (ar_empty)
    );

    always_comb begin
        wcnt_d = wcnt_q;
        case ({w_hs, b_go})
            2'b10:   wcnt_d = wcnt_q + WCW'(1);
            2'b01:   wcnt_d = wcnt_q - WCW'(1);
            default: wcnt_d = wcnt_q;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wcnt_q   <= '0;
            bvalid_q <= 1'b0;
            bid_q    <= '0;
            rvalid_q <= 1'b0;
            rid_q    <= '0;
        end else begin
            wcnt_q <= wcnt_d;
            if (b_go) begin
                bvalid_q <= 1'b1;
                bid_q    <= aw_head;
            end else if (axi4_s.bready) begin
                bvalid_q <= 1'b0;
            end
            if (r_go) begin
                rvalid_q <= 1'b1;
                rid_q    <= ar_head;
            end else if (axi4_s.rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_hits_q    <= '0;
            rd_hits_q    <= '0;
            last_waddr_q <= '0;
            last_raddr_q <= '0;
            hit_q        <= 1'b0;
        end else begin
            if (clr) begin
                wr_hits_q <= '0;
            end else if (b_hs && wr_hits_q != '1) begin
                wr_hits_q <= wr_hits_q + CW'(1);
            end
            if (clr) begin
                rd_hits_q <= '0;
            end else if (r_hs && rd_hits_q != '1) begin
                rd_hits_q <= rd_hits_q + CW'(1);
            end
            if (aw_hs) last_waddr_q <= axi4_s.awaddr;
            if (ar_hs) last_raddr_q <= axi4_s.araddr;
            // A new hit in the clearing cycle must not be lost.
            if (aw_hs || ar_hs) begin
                hit_q <= 1'b1;
            end else if (clr) begin
                hit_q <= 1'b0;
            end
        end
    end

    assign axi4_s.awready = ~aw_full;
    assign axi4_s.wready  = w_ready;
    assign axi4_s.arready = ~ar_full;
    assign axi4_s.bvalid  = bvalid_q;
    assign axi4_s.bid     = bid_q;
    assign axi4_s.bresp   = RESP;
    assign axi4_s.rvalid  = rvalid_q;
    assign axi4_s.rid     = rid_q;
    assign axi4_s.rdata   = RDATA;
    assign axi4_s.rresp   = RESP;

    assign wr_hits    = wr_hits_q;
    assign rd_hits    = rd_hits_q;
    assign last_waddr = last_waddr_q;
    assign last_raddr = last_raddr_q;
    assign hit        = hit_q;

endmodule
